// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control signal bundle: ID/EX hazard sources in, pipeline steering out.
interface hazard_ctrl_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_Div;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        Branch_Taken;
    logic        Cnt_Clr;
    logic        PC_Stall;
    logic        IFID_Stall;
    logic        IFID_Flush;
    logic        IDEX_Bubble;
    logic        Div_Busy;
    logic        Div_Done;
    logic [15:0] Stall_Cnt;

    modport master (
        output ID_Rs, ID_Rt, ID_Div, EX_MemRead, EX_Rt, Branch_Taken, Cnt_Clr,
        input  PC_Stall, IFID_Stall, IFID_Flush, IDEX_Bubble, Div_Busy, Div_Done, Stall_Cnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_Div, EX_MemRead, EX_Rt, Branch_Taken, Cnt_Clr,
        output PC_Stall, IFID_Stall, IFID_Flush, IDEX_Bubble, Div_Busy, Div_Done, Stall_Cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: branch flush, load-use stall and multi-cycle divide stall with a
// saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic          Clk,
    input logic          Rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic {StRun, StDiv} state_t;

    localparam logic [7:0] LP_CNT_INIT = 8'(DIV_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_stall_cnt;

    logic w_lu;
    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_div_busy;
    logic w_div_done;
    logic w_div_issue;

    assign w_lu = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                  ((bus.EX_Rt == bus.ID_Rs) || (bus.EX_Rt == bus.ID_Rt));

    assign w_div_issue = (r_state == StRun) && !bus.Branch_Taken && !w_lu && bus.ID_Div;

    // Outputs are forced low while reset is held, independent of the inputs.
    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_div_busy    = 1'b0;
        w_div_done    = 1'b0;
        if (!Rst) begin
            unique case (r_state)
                StRun: begin
                    if (bus.Branch_Taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (w_lu || bus.ID_Div) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end
                end
                StDiv: begin
                    w_div_busy = 1'b1;
                    if (r_cnt != 8'd0) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else begin
                        w_div_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= StRun;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_div_issue) begin
                        r_state <= StDiv;
                        r_cnt   <= LP_CNT_INIT;
                    end
                end
                StDiv: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_state <= StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_stall_cnt <= 16'd0;
        end else if (bus.Cnt_Clr) begin
            r_stall_cnt <= 16'd0;
        end else if (w_pc_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.PC_Stall    = w_pc_stall;
    assign bus.IFID_Stall  = w_ifid_stall;
    assign bus.IFID_Flush  = w_ifid_flush;
    assign bus.IDEX_Bubble = w_idex_bubble;
    assign bus.Div_Busy    = w_div_busy;
    assign bus.Div_Done    = w_div_done;
    assign bus.Stall_Cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against a
// cycle-count reference model.
module tb_hazard_ctrl;

    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.DIV_CYCLES(N)) u_dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: whether a divide holds ID, how many stall cycles it still owes,
    // and the number of stall cycles seen so far.
    bit         m_in_div;
    int         m_left;
    int         m_sc;
    logic [5:0] last_ctl;

    function automatic logic lu_now();
        return bus.EX_MemRead && (bus.EX_Rt != 0) &&
               ((bus.EX_Rt == bus.ID_Rs) || (bus.EX_Rt == bus.ID_Rt));
    endfunction

    // {PC_Stall, IFID_Stall, IFID_Flush, IDEX_Bubble, Div_Busy, Div_Done}
    function automatic logic [5:0] model_ctl();
        if (rst) return 6'b000000;
        if (m_in_div) return (m_left > 0) ? 6'b110110 : 6'b000011;
        if (bus.Branch_Taken) return 6'b001100;
        if (lu_now() || bus.ID_Div) return 6'b110100;
        return 6'b000000;
    endfunction

    function automatic logic [5:0] obs_ctl();
        return {bus.PC_Stall, bus.IFID_Stall, bus.IFID_Flush, bus.IDEX_Bubble,
                bus.Div_Busy, bus.Div_Done};
    endfunction

    task automatic check_ctl(input string tag);
        logic [5:0] o, e;
        o = obs_ctl();
        e = model_ctl();
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, o, e);
        end
        n_tests++;
        assert (bus.Stall_Cnt === 16'(m_sc)) else begin
            n_fail++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, bus.Stall_Cnt, m_sc);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit dv, input bit mr,
                          input int ert, input bit br, input bit clr);
        bus.ID_Rs        = 5'(rs);
        bus.ID_Rt        = 5'(rt);
        bus.ID_Div       = dv;
        bus.EX_MemRead   = mr;
        bus.EX_Rt        = 5'(ert);
        bus.Branch_Taken = br;
        bus.Cnt_Clr      = clr;
    endtask

    task automatic model_reset();
        m_in_div = 1'b0;
        m_left   = 0;
        m_sc     = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step(input string tag);
        logic [5:0] e;
        bit         issue;
        @(negedge clk);
        check_ctl(tag);
        e        = model_ctl();
        last_ctl = obs_ctl();
        issue    = !m_in_div && !bus.Branch_Taken && !lu_now() && bus.ID_Div;
        @(posedge clk);
        if (bus.Cnt_Clr) m_sc = 0;
        else if (e[5] && m_sc < 65535) m_sc++;
        if (m_in_div) begin
            if (m_left > 0) m_left--;
            else m_in_div = 1'b0;
        end else if (issue) begin
            m_in_div = 1'b1;
            m_left   = N - 1;
        end
        #1;
    endtask

    initial begin
        int  stalls;
        int  done_at;
        bit  saw_done;

        model_reset();
        last_ctl = '0;
        rst = 1'b1;
        set_in(5, 5, 1, 1, 5, 1, 0);
        #2;
        check_ctl("reset_forced");
        @(posedge clk);
        #1;
        set_in(5, 0, 1, 1, 5, 0, 0);
        check_ctl("reset_lu_forced");
        rst = 1'b0;

        // Load-use, single cycle
        set_in(5, 0, 0, 1, 5, 0, 0);
        step("lu_stall");
        set_in(0, 0, 0, 0, 0, 0, 0);
        step("lu_after");
        check_val("lu_stall_cnt", int'(bus.Stall_Cnt), 1);

        // Zero register never hazards
        set_in(3, 0, 0, 1, 0, 0, 0);
        step("zero_reg");

        // Branch beats load-use and divide
        set_in(7, 2, 1, 1, 7, 1, 0);
        step("branch_priority");
        set_in(0, 0, 0, 0, 0, 0, 0);
        step("no_div_entry");

        // Full divide
        set_in(0, 0, 0, 0, 0, 0, 1);
        step("clr");
        set_in(1, 2, 1, 0, 0, 0, 0);
        step("div_issue");
        stalls   = last_ctl[5] ? 1 : 0;
        done_at  = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 40 && done_at == 0; i++) begin
            step("div_run");
            if (last_ctl[5]) stalls++;
            if (last_ctl[0]) done_at = i;
        end
        check_val("div_stall_cycles", stalls, N);
        check_val("div_done_cycle", done_at, N + 1);
        check_val("div_stall_cnt", int'(bus.Stall_Cnt), N);
        step("div_back_run");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 31) == 0));
            step("random");
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < N + 2; i++) step("drain");

        // Asynchronous abort mid-divide at Cnt=10
        set_in(1, 2, 1, 0, 0, 0, 0);
        step("abort_issue");
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < N - 11; i++) step("abort_pre");
        #2;
        rst = 1'b1;
        model_reset();
        set_in(4, 4, 1, 1, 4, 1, 0);
        #1;
        check_ctl("abort_forced");
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        saw_done = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            step("abort_after");
            if (last_ctl[0]) saw_done = 1'b1;
        end
        check_val("abort_no_done", int'(saw_done), 0);

        // Saturation and clear priority
        set_in(0, 0, 0, 0, 0, 0, 1);
        step("sat_clr");
        set_in(9, 0, 0, 1, 9, 0, 0);
        for (int i = 0; i < 65535 + 3; i++) step("sat_fill");
        check_val("sat_value", int'(bus.Stall_Cnt), 16'hFFFF);
        set_in(9, 0, 0, 1, 9, 0, 1);
        step("clr_over_inc");
        check_val("clr_value", int'(bus.Stall_Cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: DIV_CYCLES, default 32, total stall cycles per divide issue; legal range 2..255.
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Rst  in  1  reset; asynchronous and active-high.
REQ-004 ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 ID_Div  in  1  instruction in ID is a multi-cycle divide.
REQ-006 EX_MemRead  in  1  instruction in EX is a load.
REQ-007 EX_Rt  in  5  load destination register in EX.
REQ-008 Branch_Taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-009 Cnt_Clr  in  1  synchronous clear of Stall_Cnt.
REQ-010 PC_Stall  out  1  hold PC, driven to the PC register's Stall input.
REQ-011 IFID_Stall  out  1  hold the IF/ID register.
REQ-012 IFID_Flush  out  1  zero the IF/ID register.
REQ-013 IDEX_Bubble  out  1  load a NOP into ID/EX.
REQ-014 Div_Busy  out  1  high while in state DIV.
REQ-015 Div_Done  out  1  one-cycle pulse on divide release.
REQ-016 Stall_Cnt  out  16  count of cycles with PC_Stall=1.

Function
REQ-017 FSM has exactly two states, RUN and DIV, plus an 8-bit down-counter Cnt.
REQ-018 Load-use hazard LU = EX_MemRead & (EX_Rt!=0) & (EX_Rt==ID_Rs | EX_Rt==ID_Rt).
REQ-019 RUN priority, highest first: Branch_Taken, LU, ID_Div.
REQ-020 RUN, Branch_Taken=1: IFID_Flush=1, IDEX_Bubble=1, PC_Stall=0, IFID_Stall=0; state stays RUN; LU and ID_Div ignored.
REQ-021 RUN, LU=1 and no branch: PC_Stall=1, IFID_Stall=1, IDEX_Bubble=1, IFID_Flush=0; state stays RUN; ID_Div ignored that cycle.
REQ-022 RUN, ID_Div=1 and neither higher condition holds:
  - PC_Stall=1, IFID_Stall=1, IDEX_Bubble=1.
  - Next state DIV, with Cnt loaded to DIV_CYCLES-1.
REQ-023 RUN, no condition: all control outputs 0.
REQ-024 DIV, Cnt!=0: PC_Stall=1, IFID_Stall=1, IDEX_Bubble=1, Div_Busy=1; Cnt decrements by 1.
REQ-025 DIV, Cnt==0:
  - Stall outputs 0, Div_Busy=1, Div_Done=1.
  - Next state RUN, so the divide leaves ID.
REQ-026 A divide issue produces exactly DIV_CYCLES consecutive PC_Stall cycles, followed by one release cycle.
REQ-027 In DIV, Branch_Taken, LU and ID_Div are ignored; IFID_Flush stays 0.
REQ-028 Outputs are combinational from state, Cnt and inputs; no input-to-output path exists except through the REQ-020..REQ-025 decode.
REQ-029 Stall_Cnt:
  - Increments by 1 on each Clk edge where PC_Stall=1.
  - Saturates at 16'hFFFF; no wrap-around.
  - Cnt_Clr=1 loads 0 and has priority over increment.

Reset
REQ-030 While Rst=1, asynchronously: state=RUN, Cnt=0, Stall_Cnt=0, all 1-bit outputs forced 0 regardless of inputs.
REQ-031 Rst asserted during DIV aborts the divide: after release the block is in RUN with no Div_Done pulse.
REQ-032 The first Clk edge after Rst falls evaluates RUN normally.

Verification
REQ-033 Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle -> PC_Stall=IFID_Stall=IDEX_Bubble=1 that cycle only; Stall_Cnt=1.
REQ-034 Zero register: EX_MemRead=1, EX_Rt=0, ID_Rt=0 -> no stall.
REQ-035 Divide, DIV_CYCLES=32: ID_Div=1 in RUN -> PC_Stall high 32 consecutive cycles; Div_Done=1 on cycle 33; Stall_Cnt=32; back in RUN.
REQ-036 Simultaneous events: Branch_Taken=1 with LU=1 and ID_Div=1 -> IFID_Flush=1, IDEX_Bubble=1, PC_Stall=0; no DIV entry.
REQ-037 Async abort: Rst pulsed mid-divide at Cnt=10, between edges -> outputs 0 immediately; RUN after release; Div_Done never asserted.
REQ-038 Saturation: preload via 65535 stall cycles, then 3 more -> Stall_Cnt=16'hFFFF; Cnt_Clr=1 together with PC_Stall=1 -> Stall_Cnt=0.
